// File: rtl/node_injection_interface_pkg.sv
// Shared configuration for the node injection interface.
// Purpose: mesh size, ant period, packet layout and the node-index helper.
// No ports; imported by the interface, the FIFO and the top level.

`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef NODES
`define NODES (`X_NODES * `Y_NODES)
`endif
`ifndef CREATE_ANT_PERIOD
`define CREATE_ANT_PERIOD 10
`endif

package node_injection_interface_pkg;

  localparam int X_NODES           = `X_NODES;
  localparam int Y_NODES           = `Y_NODES;
  localparam int NODES             = `NODES;
  localparam int CREATE_ANT_PERIOD = `CREATE_ANT_PERIOD;

  localparam int X_W          = $clog2(X_NODES + 1);
  localparam int Y_W          = $clog2(Y_NODES + 1);
  localparam int NODE_W       = $clog2(NODES);
  localparam int ID_W         = 8;
  localparam int TS_W         = 16;
  localparam int MAX_MEMORIES = 4;
  localparam int NUM_MEM_W    = $clog2(MAX_MEMORIES + 1);

  typedef struct packed {
    logic [ID_W-1:0]                        id;
    logic [X_W-1:0]                         x_source;
    logic [Y_W-1:0]                         y_source;
    logic [X_W-1:0]                         x_dest;
    logic [Y_W-1:0]                         y_dest;
    logic                                   ant;
    logic                                   backward;
    logic                                   measure;
    logic [TS_W-1:0]                        timestamp;
    logic [MAX_MEMORIES-1:0][NODE_W-1:0]    memories;
    logic [NUM_MEM_W-1:0]                   num_memories;
  } packet_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

  // Row-major node numbering: index = y * X_NODES + x.
  function automatic coord_t node_index_to_xy(input logic [NODE_W-1:0] d);
    coord_t c;
    int     di;
    di  = int'(d);
    c.x = X_W'(di % X_NODES);
    c.y = Y_W'(di / X_NODES);
    return c;
  endfunction

endpackage

// File: rtl/node_injection_interface_if.sv
// Bundle of the node-side request bus and router-side output bus.
// slave  : seen by node_injection_interface (requests in, packets out).
// master : seen by whatever drives requests and models the router.
//   i_req_val/i_req_x_dest/i_req_y_dest/i_req_measure : node request
//   o_req_en : request accepted when high
//   o_data/o_data_val/i_en : packet to router with router backpressure
//   o_injected_count/o_ant_drop_count : statistics

interface node_injection_interface_if;
  import node_injection_interface_pkg::*;

  logic             i_req_val;
  logic [X_W-1:0]   i_req_x_dest;
  logic [Y_W-1:0]   i_req_y_dest;
  logic             i_req_measure;
  logic             o_req_en;
  packet_t          o_data;
  logic             o_data_val;
  logic             i_en;
  logic [31:0]      o_injected_count;
  logic [31:0]      o_ant_drop_count;

  modport slave (
    input  i_req_val, i_req_x_dest, i_req_y_dest, i_req_measure, i_en,
    output o_req_en, o_data, o_data_val, o_injected_count, o_ant_drop_count
  );

  modport master (
    output i_req_val, i_req_x_dest, i_req_y_dest, i_req_measure, i_en,
    input  o_req_en, o_data, o_data_val, o_injected_count, o_ant_drop_count
  );
endinterface

// File: rtl/node_injection_interface_packet_fifo.sv
// packet_fifo: pointer-based FIFO of packets.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i/din_i : write din_i when not full
//   pop_i        : drop the head when not empty
//   full_o/empty_o/head_o : status and current head entry
// Pointers carry one extra wrap bit so equal indexes can be told apart
// as full (wrap bits differ) or empty (wrap bits equal).

module packet_fifo
  import node_injection_interface_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = packet_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);
  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Head is read combinationally so a pop lands in the consumer's
  // register on the same edge.
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/node_injection_interface.sv
// node_injection_interface: local-node injection stage feeding router port 0.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : node requests in, one packet per cycle out to the router
// Requests are stamped (id, source, cycle timestamp) and queued. Forward
// ants are generated every ANT_PERIOD cycles round-robin over the other
// nodes and take priority over queued data when the output register loads.

module node_injection_interface
  import node_injection_interface_pkg::*;
#(
  parameter int X_LOC       = 0,
  parameter int Y_LOC       = 0,
  parameter int QUEUE_DEPTH = 8,
  parameter int ANT_PERIOD  = CREATE_ANT_PERIOD
) (
  input  logic                           clk,
  input  logic                           reset_n,
  node_injection_interface_if.slave      bus
);
  localparam int OWN_IDX = Y_LOC * X_NODES + X_LOC;
  localparam int AP_W    = $clog2(ANT_PERIOD);

  logic [AP_W-1:0]   ant_cnt_q;
  logic              ant_pending_q, ant_pending_d;
  logic [NODE_W-1:0] ant_idx_q, ant_dst;
  logic [ID_W-1:0]   id_q, id_d;
  logic [TS_W-1:0]   cycle_q;
  logic [31:0]       inj_q, drop_q;
  packet_t           out_q, out_d;
  logic              val_q, val_d;

  logic    accept, load, ant_load, pop, wrap;
  logic    fifo_full, fifo_empty;
  packet_t push_pkt, ant_pkt, head;
  coord_t  ant_xy;

  function automatic logic [NODE_W-1:0] next_idx(input logic [NODE_W-1:0] i);
    return (i == NODE_W'(NODES - 1)) ? '0 : i + NODE_W'(1);
  endfunction

  packet_fifo #(.DEPTH(QUEUE_DEPTH), .T(packet_t)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (accept),
    .din_i   (push_pkt),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign accept   = bus.i_req_val && !fifo_full;
  assign load     = !val_q || bus.i_en;
  assign ant_load = load && ant_pending_q;
  assign pop      = load && !ant_pending_q && !fifo_empty;
  assign wrap     = (ant_cnt_q == AP_W'(ANT_PERIOD - 1));
  // The round-robin pointer may rest on our own index; step past it.
  assign ant_dst  = (ant_idx_q == NODE_W'(OWN_IDX)) ? next_idx(ant_idx_q) : ant_idx_q;
  // A wrap while an ant still waits is a drop; otherwise it arms a new ant.
  assign ant_pending_d = (ant_pending_q && !ant_load) || (wrap && !ant_pending_q);
  // Data acceptance takes id n; an ant loaded on the same edge takes n+1.
  assign id_d = id_q + ID_W'(accept) + ID_W'(ant_load);

  always_comb begin
    push_pkt           = '0;
    push_pkt.id        = id_q;
    push_pkt.x_source  = X_W'(X_LOC);
    push_pkt.y_source  = Y_W'(Y_LOC);
    push_pkt.x_dest    = bus.i_req_x_dest;
    push_pkt.y_dest    = bus.i_req_y_dest;
    push_pkt.measure   = bus.i_req_measure;
    push_pkt.timestamp = cycle_q;

    ant_xy             = node_index_to_xy(ant_dst);
    ant_pkt            = '0;
    ant_pkt.id         = id_q + ID_W'(accept);
    ant_pkt.ant        = 1'b1;
    ant_pkt.x_source   = X_W'(X_LOC);
    ant_pkt.y_source   = Y_W'(Y_LOC);
    ant_pkt.x_dest     = ant_xy.x;
    ant_pkt.y_dest     = ant_xy.y;
    ant_pkt.timestamp  = cycle_q;

    out_d = out_q;
    val_d = val_q;
    if (load) begin
      if (ant_pending_q) begin
        out_d = ant_pkt;
        val_d = 1'b1;
      end else if (!fifo_empty) begin
        out_d = head;
        val_d = 1'b1;
      end else begin
        val_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ant_cnt_q     <= '0;
      ant_pending_q <= 1'b0;
      ant_idx_q     <= '0;
      id_q          <= '0;
      cycle_q       <= '0;
      inj_q         <= '0;
      drop_q        <= '0;
      out_q         <= '0;
      val_q         <= 1'b0;
    end else begin
      ant_cnt_q     <= wrap ? '0 : ant_cnt_q + AP_W'(1);
      ant_pending_q <= ant_pending_d;
      if (ant_load) ant_idx_q <= next_idx(ant_dst);
      id_q          <= id_d;
      cycle_q       <= cycle_q + TS_W'(1);
      if (val_q && bus.i_en) inj_q <= inj_q + 32'd1;
      if (wrap && ant_pending_q && (drop_q != '1)) drop_q <= drop_q + 32'd1;
      out_q         <= out_d;
      val_q         <= val_d;
    end
  end

  assign bus.o_req_en         = !fifo_full;
  assign bus.o_data           = out_q;
  assign bus.o_data_val       = val_q;
  assign bus.o_injected_count = inj_q;
  assign bus.o_ant_drop_count = drop_q;
endmodule

// File: tb/tb_node_injection_interface.sv
// Self-checking bench for node_injection_interface: randomized requests and
// backpressure compared cycle by cycle against a queue-based reference model.

module tb_node_injection_interface;
  import node_injection_interface_pkg::*;

  localparam int XL = 1, YL = 2, DEPTH = 8, PERIOD = 10;
  localparam int OWN = YL * X_NODES + XL;

  typedef struct packed {
    logic        req_en;
    logic        val;
    packet_t     data;
    logic [31:0] inj;
    logic [31:0] drop;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  node_injection_interface_if bus();

  node_injection_interface #(
    .X_LOC(XL), .Y_LOC(YL), .QUEUE_DEPTH(DEPTH), .ANT_PERIOD(PERIOD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_miss = 0;

  // reference model state
  packet_t     m_q[$];
  packet_t     m_out;
  bit          m_val, m_pend;
  int          m_cnt, m_ants, m_id, m_cycle, m_accepted;
  logic [31:0] m_inj, m_drop;

  packet_t dut_log[$];
  obs_t    got, expv;

  function automatic obs_t dut_obs();
    obs_t o;
    o.req_en = bus.o_req_en;
    o.val    = bus.o_data_val;
    o.data   = bus.o_data_val ? bus.o_data : '0;
    o.inj    = bus.o_injected_count;
    o.drop   = bus.o_ant_drop_count;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.req_en = (m_q.size() < DEPTH);
    o.val    = m_val;
    o.data   = m_val ? m_out : '0;
    o.inj    = m_inj;
    o.drop   = m_drop;
    return o;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_out = '0; m_val = 0; m_pend = 0;
    m_cnt = 0; m_ants = 0; m_id = 0; m_cycle = 0; m_accepted = 0;
    m_inj = 0; m_drop = 0;
    dut_log.delete();
  endtask

  // One clock edge of the reference behaviour, from the current inputs.
  task automatic model_step();
    bit      acc, ld, old_pend;
    packet_t p, a;
    int      k, d;
    acc      = bus.i_req_val && (m_q.size() < DEPTH);
    ld       = !m_val || bus.i_en;
    old_pend = m_pend;
    p        = '0;
    if (m_val && bus.i_en) m_inj = m_inj + 1;
    if (acc) begin
      p.id = ID_W'(m_id); m_id++;
      p.x_source = X_W'(XL); p.y_source = Y_W'(YL);
      p.x_dest = bus.i_req_x_dest; p.y_dest = bus.i_req_y_dest;
      p.measure = bus.i_req_measure; p.timestamp = TS_W'(m_cycle);
      m_accepted++;
    end
    if (ld) begin
      if (m_pend) begin
        // k-th ant goes to the k-th other node in ascending index order
        k = m_ants % (NODES - 1);
        d = (k < OWN) ? k : k + 1;
        a = '0;
        a.id = ID_W'(m_id); m_id++;
        a.ant = 1'b1;
        a.x_source = X_W'(XL); a.y_source = Y_W'(YL);
        a.x_dest = X_W'(d % X_NODES); a.y_dest = Y_W'(d / X_NODES);
        a.timestamp = TS_W'(m_cycle);
        m_ants++; m_pend = 0;
        m_out = a; m_val = 1;
      end else if (m_q.size() > 0) begin
        m_out = m_q.pop_front(); m_val = 1;
      end else begin
        m_val = 0;
      end
    end
    if (acc) m_q.push_back(p);
    if (m_cnt == PERIOD - 1) begin
      m_cnt = 0;
      if (!old_pend) m_pend = 1;
      else if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
    end else begin
      m_cnt++;
    end
    m_cycle++;
  endtask

  // Advance one clock: log DUT transfer, step model, sample at negedge.
  task automatic tick();
    if (bus.o_data_val && bus.i_en) dut_log.push_back(bus.o_data);
    model_step();
    @(posedge clk);
    @(negedge clk);
    got  = dut_obs();
    expv = model_obs();
  endtask

  task automatic drive_req(input bit v);
    bus.i_req_val     = v;
    bus.i_req_x_dest  = X_W'($urandom_range(0, X_NODES - 1));
    bus.i_req_y_dest  = Y_W'($urandom_range(0, Y_NODES - 1));
    bus.i_req_measure = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_req(0);
    bus.i_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t z;
    do_reset();
    z = '0; z.req_en = 1'b1;
    got = dut_obs();
    n_vec++;
    if (got !== z) begin
      n_miss++; $display("FAIL reset_state: got %h required %h", got, z);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.i_en = 1'b1;
    drive_req(1);
    bus.i_req_x_dest = 3; bus.i_req_y_dest = 2;
    tick();
    n_vec++;
    if (got !== expv || got.val !== 1'b0) begin
      n_miss++; $display("FAIL single_accept: got %h required %h", got, expv);
    end
    drive_req(0);
    tick();
    n_vec++;
    if (got !== expv || !(got.val === 1'b1 && got.data.x_dest === 3 &&
        got.data.y_dest === 2 && got.data.ant === 1'b0 && got.data.id === 0)) begin
      n_miss++; $display("FAIL single_output: got %h required %h", got, expv);
    end
    tick();
    n_vec++;
    if (got !== expv || bus.o_injected_count !== 32'd1) begin
      n_miss++; $display("FAIL single_count: got %0d required 1", bus.o_injected_count);
    end
  endtask

  task automatic test_fill();
    int n_acc, nd;
    do_reset();
    bus.i_en = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive_req(1);
      if (!bus.o_req_en) break;
      n_acc++;
      tick();
      n_vec++;
      if (got !== expv) begin
        n_miss++; $display("FAIL fill_cycle %0d: got %h required %h", i, got, expv);
      end
    end
    n_vec++;
    if (n_acc != 9) begin
      n_miss++; $display("FAIL fill_accepts: got %0d required 9", n_acc);
    end
    drive_req(0);
    bus.i_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_vec++;
      if (got !== expv) begin
        n_miss++; $display("FAIL fill_drain %0d: got %h required %h", i, got, expv);
      end
    end
    nd = 0;
    foreach (dut_log[i]) begin
      if (!dut_log[i].ant) begin
        n_vec++;
        if (dut_log[i].id !== ID_W'(nd)) begin
          n_miss++; $display("FAIL fill_order %0d: got id %0d required %0d", nd, dut_log[i].id, nd);
        end
        nd++;
      end
    end
    n_vec++;
    if (nd != 9) begin
      n_miss++; $display("FAIL fill_delivered: got %0d required 9", nd);
    end
  endtask

  task automatic test_ants();
    int others[$];
    int na;
    do_reset();
    bus.i_en = 1'b1;
    for (int n = 0; n < NODES; n++) if (n != OWN) others.push_back(n);
    for (int i = 0; i < 170; i++) begin
      tick();
      n_vec++;
      if (got !== expv) begin
        n_miss++; $display("FAIL ants_cycle %0d: got %h required %h", i, got, expv);
      end
    end
    na = 0;
    foreach (dut_log[i]) begin
      if (dut_log[i].ant) begin
        n_vec++;
        if (dut_log[i].x_dest !== X_W'(others[na % (NODES-1)] % X_NODES) ||
            dut_log[i].y_dest !== Y_W'(others[na % (NODES-1)] / X_NODES) ||
            (dut_log[i].x_dest == XL && dut_log[i].y_dest == YL) ||
            dut_log[i].timestamp !== TS_W'(PERIOD + PERIOD * na)) begin
          n_miss++;
          $display("FAIL ant_dest %0d: got (%0d,%0d) t=%0d required node %0d t=%0d", na,
                   dut_log[i].x_dest, dut_log[i].y_dest, dut_log[i].timestamp,
                   others[na % (NODES-1)], PERIOD + PERIOD * na);
        end
        na++;
      end
    end
    n_vec++;
    if (na != 16) begin
      n_miss++; $display("FAIL ant_count: got %0d required 16", na);
    end
  endtask

  task automatic test_stall_drop();
    int pos;
    do_reset();
    bus.i_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive_req(i == 12);
      tick();
      n_vec++;
      if (got !== expv) begin
        n_miss++; $display("FAIL stall_cycle %0d: got %h required %h", i, got, expv);
      end
    end
    drive_req(0);
    n_vec++;
    if (bus.o_ant_drop_count !== 32'd1 || dut_log.size() != 0) begin
      n_miss++; $display("FAIL stall_drop: got drops %0d delivered %0d required 1 and 0",
                         bus.o_ant_drop_count, dut_log.size());
    end
    bus.i_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (got !== expv) begin
        n_miss++; $display("FAIL stall_release %0d: got %h required %h", i, got, expv);
      end
    end
    pos = -1;
    foreach (dut_log[i]) if (!dut_log[i].ant && pos < 0) pos = i;
    n_vec++;
    if (pos < 1 || dut_log[0].ant !== 1'b1) begin
      n_miss++; $display("FAIL stall_order: data at position %0d required after an ant", pos);
    end
  endtask

  task automatic test_toggle();
    bit held;
    packet_t prev;
    int nd, last_id;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus.i_en = (i % 2 == 0);
      drive_req(1'($urandom_range(0, 1)));
      held = bus.o_data_val && !bus.i_en;
      prev = bus.o_data;
      tick();
      if (held) begin
        n_vec++;
        if (bus.o_data_val !== 1'b1 || bus.o_data !== prev) begin
          n_miss++; $display("FAIL toggle_hold %0d: got %h required %h", i, bus.o_data, prev);
        end
      end
      n_vec++;
      if (got !== expv) begin
        n_miss++; $display("FAIL toggle_cycle %0d: got %h required %h", i, got, expv);
      end
    end
    drive_req(0);
    bus.i_en = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    nd = 0; last_id = -1;
    foreach (dut_log[i]) begin
      if (!dut_log[i].ant) begin
        n_vec++;
        if (int'(dut_log[i].id) <= last_id) begin
          n_miss++; $display("FAIL toggle_dup: got id %0d after %0d", dut_log[i].id, last_id);
        end
        last_id = int'(dut_log[i].id);
        nd++;
      end
    end
    n_vec++;
    if (nd != m_accepted || bus.o_injected_count !== 32'(dut_log.size()) || got !== expv) begin
      n_miss++; $display("FAIL toggle_totals: got data %0d inj %0d required %0d and %0d",
                         nd, bus.o_injected_count, m_accepted, dut_log.size());
    end
  endtask

  task automatic test_async_reset();
    obs_t z;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.i_en = 1'($urandom_range(0, 1));
      drive_req(1);
      tick();
      n_vec++;
      if (got !== expv) begin
        n_miss++; $display("FAIL areset_pre %0d: got %h required %h", i, got, expv);
      end
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    z = '0; z.req_en = 1'b1;
    got = dut_obs();
    n_vec++;
    if (got !== z || bus.o_data !== '0) begin
      n_miss++; $display("FAIL areset_now: got %h required %h", got, z);
    end
    @(negedge clk);
    drive_req(0);
    bus.i_en = 1'b1;
    reset_n = 1'b1;
    model_reset();
    drive_req(1);
    for (int i = 0; i < 6; i++) begin
      tick();
      drive_req(0);
      n_vec++;
      if (got !== expv) begin
        n_miss++; $display("FAIL areset_post %0d: got %h required %h", i, got, expv);
      end
    end
  endtask

  initial begin
    bus.i_en = 1'b0;
    drive_req(0);
    test_reset();
    test_single();
    test_fill();
    test_ants();
    test_stall_drop();
    test_toggle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
